// File: rtl/memory_stall_controller.sv
// Data-memory request sequencer beside the execute stage: load/store handshake,
// pipeline stall/flush generation and stage-3 to execute forwarding selects.
module memory_stall_controller #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction_execute,
  input  logic        br_taken,
  input  logic        reg_write_memory_write,
  input  logic [4:0]  rd_memory_write,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        stall_fetch,
  output logic        stall_memory_write,
  output logic        flush,
  output logic        forward_a,
  output logic        forward_b,
  output logic        bus_error,
  output logic        busy
);

  typedef enum logic {IDLE, REQ} state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [3:0] LAST_CNT = 4'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       dmem_we_q, dmem_we_d;

  logic       is_load, is_store, mem_op;
  logic       stall_raw, bus_error_raw, req_raw;
  logic       fwd_a_raw, fwd_b_raw;

  assign is_load  = (instruction_execute[6:0] == OP_LOAD);
  assign is_store = (instruction_execute[6:0] == OP_STORE);
  assign mem_op   = is_load | is_store;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= 4'd0;
      dmem_we_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      dmem_we_q  <= dmem_we_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    dmem_we_d     = dmem_we_q;
    stall_raw     = 1'b0;
    bus_error_raw = 1'b0;
    req_raw       = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          stall_raw  = 1'b1;
          state_d    = REQ;
          dmem_we_d  = is_store;
          wait_cnt_d = 4'd0;
        end
      end
      REQ: begin
        req_raw = 1'b1;
        if (dmem_ack) begin
          state_d = IDLE;
        end else if (wait_cnt_q == LAST_CNT) begin
          // Abort: let the instruction retire rather than hang the pipeline.
          bus_error_raw = 1'b1;
          state_d       = IDLE;
        end else begin
          stall_raw  = 1'b1;
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fwd_a_raw = reg_write_memory_write && (rd_memory_write != 5'd0) &&
                     (rd_memory_write == instruction_execute[19:15]);
  assign fwd_b_raw = reg_write_memory_write && (rd_memory_write != 5'd0) &&
                     (rd_memory_write == instruction_execute[24:20]);

  // Reset forces every output low, including the purely combinational ones.
  assign dmem_req           = ~rst & req_raw;
  assign busy               = ~rst & req_raw;
  assign dmem_we            = ~rst & dmem_we_q;
  assign stall_fetch        = ~rst & stall_raw;
  assign stall_memory_write = ~rst & stall_raw;
  assign flush              = ~rst & br_taken & ~stall_raw;
  assign bus_error          = ~rst & bus_error_raw;
  assign forward_a          = ~rst & fwd_a_raw;
  assign forward_b          = ~rst & fwd_b_raw;

endmodule

// File: tb/tb_memory_stall_controller.sv
// Self-checking bench: directed scenarios then random traffic, each cycle
// compared against a transaction-level reference model of the handshake.
module tb_memory_stall_controller;

  localparam int TIMEOUT = 8;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ADD   = 7'b0110011;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction_execute;
  logic        br_taken;
  logic        reg_write_memory_write;
  logic [4:0]  rd_memory_write;
  logic        dmem_ack;
  logic        dmem_req, dmem_we, stall_fetch, stall_memory_write, flush;
  logic        forward_a, forward_b, bus_error, busy;

  int checks = 0;
  int errors = 0;

  // Reference model: is a request outstanding, how many REQ cycles it has
  // already spent, and which direction it carries.
  bit m_pending = 0;
  int m_age     = 0;
  bit m_store   = 0;

  int stall_cnt = 0;
  int req_cnt   = 0;
  int berr_cnt  = 0;

  memory_stall_controller #(.TIMEOUT(TIMEOUT)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .instruction_execute    (instruction_execute),
    .br_taken               (br_taken),
    .reg_write_memory_write (reg_write_memory_write),
    .rd_memory_write        (rd_memory_write),
    .dmem_ack               (dmem_ack),
    .dmem_req               (dmem_req),
    .dmem_we                (dmem_we),
    .stall_fetch            (stall_fetch),
    .stall_memory_write     (stall_memory_write),
    .flush                  (flush),
    .forward_a              (forward_a),
    .forward_b              (forward_b),
    .bus_error              (bus_error),
    .busy                   (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, 5'd1, op};
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, check outputs mid-cycle, then advance the model.
  task automatic cyc(input bit r, input logic [31:0] ins, input bit br, input bit rw,
                     input logic [4:0] rd, input bit ack);
    bit mem, st, e_stall, e_berr, e_fa, e_fb;
    rst = r; instruction_execute = ins; br_taken = br;
    reg_write_memory_write = rw; rd_memory_write = rd; dmem_ack = ack;
    @(negedge clk);
    mem = (ins[6:0] == OP_LOAD) || (ins[6:0] == OP_STORE);
    st  = (ins[6:0] == OP_STORE);
    e_stall = m_pending ? (!ack && m_age < TIMEOUT - 1) : mem;
    e_berr  = m_pending && !ack && (m_age == TIMEOUT - 1);
    e_fa = rw && rd != 0 && rd == ins[19:15];
    e_fb = rw && rd != 0 && rd == ins[24:20];
    if (r) begin
      e_stall = 0; e_berr = 0; e_fa = 0; e_fb = 0;
    end
    $display("t=%0t rst=%0b op=%07b ack=%0b br=%0b | req=%0b we=%0b stall=%0b flush=%0b fa=%0b fb=%0b berr=%0b busy=%0b",
             $time, r, ins[6:0], ack, br, dmem_req, dmem_we, stall_fetch, flush,
             forward_a, forward_b, bus_error, busy);
    check("dmem_req", int'(dmem_req), int'(!r && m_pending));
    check("busy", int'(busy), int'(!r && m_pending));
    if (!r && m_pending) check("dmem_we", int'(dmem_we), int'(m_store));
    if (r) check("dmem_we_rst", int'(dmem_we), 0);
    check("stall_fetch", int'(stall_fetch), int'(e_stall));
    check("stall_mw", int'(stall_memory_write), int'(e_stall));
    check("flush", int'(flush), int'(!r && br && !e_stall));
    check("bus_error", int'(bus_error), int'(e_berr));
    check("forward_a", int'(forward_a), int'(e_fa));
    check("forward_b", int'(forward_b), int'(e_fb));
    stall_cnt += int'(stall_fetch);
    req_cnt   += int'(dmem_req);
    berr_cnt  += int'(bus_error);
    if (r) begin
      m_pending = 0; m_age = 0; m_store = 0;
    end else if (!m_pending) begin
      if (mem) begin
        m_pending = 1; m_age = 0; m_store = st;
      end
    end else if (ack || m_age == TIMEOUT - 1) begin
      m_pending = 0;
    end else begin
      m_age++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    stall_cnt = 0; req_cnt = 0; berr_cnt = 0;
  endtask

  initial begin
    logic [31:0] ld, st, add;
    ld  = mk(OP_LOAD, 5'd2, 5'd3);
    st  = mk(OP_STORE, 5'd4, 5'd7);
    add = mk(OP_ADD, 5'd9, 5'd10);

    // Reset with a load and taken branch present
    cyc(1, ld, 1, 1, 5'd2, 0);
    cyc(1, ld, 1, 1, 5'd2, 0);
    clr_counts();
    cyc(0, ld, 0, 0, 5'd0, 0);
    cyc(0, ld, 0, 0, 5'd0, 1);
    check("post_reset_stalls", stall_cnt, 1);
    check("post_reset_req", req_cnt, 1);

    // Load, ack in third REQ cycle
    clr_counts();
    cyc(0, ld, 0, 0, 5'd0, 0);
    cyc(0, ld, 0, 0, 5'd0, 0);
    cyc(0, ld, 0, 0, 5'd0, 0);
    cyc(0, ld, 0, 0, 5'd0, 1);
    cyc(0, add, 0, 0, 5'd0, 0);
    check("load3_stalls", stall_cnt, 3);
    check("load3_req", req_cnt, 3);

    // Back-to-back stores, each acked in the first REQ cycle
    for (int k = 0; k < 2; k++) begin
      clr_counts();
      cyc(0, st, 0, 0, 5'd0, 0);
      cyc(0, st, 0, 0, 5'd0, 1);
      check("store_stalls", stall_cnt, 1);
      check("store_req", req_cnt, 1);
    end

    // Timeout with ack held low
    clr_counts();
    cyc(0, ld, 0, 0, 5'd0, 0);
    for (int k = 0; k < TIMEOUT; k++) cyc(0, ld, 0, 0, 5'd0, 0);
    check("timeout_req_cycles", req_cnt, TIMEOUT);
    check("timeout_berr_pulses", berr_cnt, 1);
    check("timeout_stalls", stall_cnt, TIMEOUT);
    cyc(0, add, 0, 0, 5'd0, 0);

    // Flush on taken branch with no memory op
    cyc(0, add, 1, 0, 5'd0, 0);

    // Forwarding cases
    cyc(0, mk(OP_ADD, 5'd5, 5'd6), 0, 1, 5'd5, 0);
    cyc(0, mk(OP_ADD, 5'd0, 5'd6), 0, 1, 5'd0, 0);
    cyc(0, mk(OP_ADD, 5'd5, 5'd5), 0, 0, 5'd5, 0);
    cyc(0, mk(OP_ADD, 5'd8, 5'd8), 0, 1, 5'd8, 0);

    // Reset in the second REQ cycle, then a normal load
    clr_counts();
    cyc(0, ld, 0, 0, 5'd0, 0);
    cyc(0, ld, 0, 0, 5'd0, 0);
    cyc(1, ld, 0, 0, 5'd0, 0);
    check("midreq_reset_berr", berr_cnt, 0);
    clr_counts();
    cyc(0, ld, 0, 0, 5'd0, 0);
    cyc(0, ld, 0, 0, 5'd0, 0);
    cyc(0, ld, 0, 0, 5'd0, 0);
    cyc(0, ld, 0, 0, 5'd0, 1);
    cyc(0, add, 0, 0, 5'd0, 0);
    check("reload_stalls", stall_cnt, 3);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      logic [6:0] op;
      case ($urandom_range(3))
        0: op = OP_LOAD;
        1: op = OP_STORE;
        2: op = OP_ADD;
        default: op = OP_BR;
      endcase
      cyc($urandom_range(49) == 0, mk(op, 5'($urandom_range(7)), 5'($urandom_range(7))),
          $urandom_range(1) == 1, $urandom_range(1) == 1, 5'($urandom_range(7)),
          $urandom_range(9) < 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
